// File: rtl/router_pkg.sv
// Shared router types and constants: scheduler state encoding, the two
// routable address codes and the statistics counter width.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    localparam logic [1:0] ADDR_PORT1 = 2'b01;
    localparam logic [1:0] ADDR_PORT2 = 2'b10;

    localparam int STAT_W = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the channel that wins a
// tie; it moves to the channel that was not served on every accept strobe.
module rr_arbiter2 (
    input  logic clock,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic accept,
    output logic grant_a,
    output logic grant_b
);

    // 0: A wins a tie, 1: B wins a tie
    logic ptr_reg;

    // One-hot grant from the requests and the tie-break pointer
    always_comb begin
        grant_a = req_a && (!req_b || !ptr_reg);
        grant_b = req_b && (!req_a ||  ptr_reg);
    end

    // Pointer moves away from whichever channel was just served
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_reg <= 1'b0;
        end else if (accept) begin
            ptr_reg <= grant_a;
        end
    end

endmodule

// File: rtl/route_scheduler.sv
// Schedules packets from two receive channels onto two output ports, with
// registered one-hot LED indications held for a fixed display time.
// Optional statistics counters are built when ROUTE_STATS_EN is defined.
module route_scheduler
    import router_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 1000,
    parameter int TIMEOUT     = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_a_valid,
    input  logic [DATA_W-1:0] req_a_data,
    output logic              req_a_ready,
    input  logic              req_b_valid,
    input  logic [DATA_W-1:0] req_b_data,
    output logic              req_b_ready,
    output logic              port1_valid,
    output logic [DATA_W-1:0] port1_data,
    input  logic              port1_ready,
    output logic              port2_valid,
    output logic [DATA_W-1:0] port2_data,
    input  logic              port2_ready,
    output logic              ind_port1,
    output logic              ind_port2,
    output logic              ind_error,
    output logic              busy
`ifdef ROUTE_STATS_EN
    ,
    output logic [STAT_W-1:0] fwd_count,
    output logic [STAT_W-1:0] drop_count
`endif
);

    // One down-counter serves both the SEND timeout and the HOLD display time
    localparam int MAX_CNT = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT - 1);

    sched_state_t      state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              to_port2_reg, to_port2_next;
    logic              ind_port1_reg, ind_port1_next;
    logic              ind_port2_reg, ind_port2_next;
    logic              ind_error_reg, ind_error_next;

    logic              grant_a, grant_b, accept;
    logic [DATA_W-1:0] acc_data;
    logic [1:0]        acc_addr;
    logic              sel_ready;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req_a   (req_a_valid),
        .req_b   (req_b_valid),
        .accept  (accept),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    // Upstream handshake; reset is folded in so readies are low while it is held
    always_comb begin
        req_a_ready = !reset && (state_reg == IDLE) && grant_a;
        req_b_ready = !reset && (state_reg == IDLE) && grant_b;
        accept      = req_a_ready || req_b_ready;
        acc_data    = grant_a ? req_a_data : req_b_data;
        acc_addr    = acc_data[DATA_W-1:DATA_W-2];
        sel_ready   = to_port2_reg ? port2_ready : port1_ready;
    end

    // Next-state, counter and indication logic
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        data_next      = data_reg;
        to_port2_next  = to_port2_reg;
        ind_port1_next = ind_port1_reg;
        ind_port2_next = ind_port2_reg;
        ind_error_next = ind_error_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    data_next = acc_data;
                    if (acc_addr == ADDR_PORT1) begin
                        state_next     = SEND;
                        to_port2_next  = 1'b0;
                        ind_port1_next = 1'b1;
                        cnt_next       = TO_LOAD;
                    end else if (acc_addr == ADDR_PORT2) begin
                        state_next     = SEND;
                        to_port2_next  = 1'b1;
                        ind_port2_next = 1'b1;
                        cnt_next       = TO_LOAD;
                    end else begin
                        state_next     = HOLD;
                        ind_error_next = 1'b1;
                        cnt_next       = HOLD_LOAD;
                    end
                end
            end
            SEND: begin
                if (sel_ready) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next     = HOLD;
                    ind_port1_next = 1'b0;
                    ind_port2_next = 1'b0;
                    ind_error_next = 1'b1;
                    cnt_next       = HOLD_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_reg == '0) begin
                    state_next     = IDLE;
                    ind_port1_next = 1'b0;
                    ind_port2_next = 1'b0;
                    ind_error_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            data_reg      <= '0;
            to_port2_reg  <= 1'b0;
            ind_port1_reg <= 1'b0;
            ind_port2_reg <= 1'b0;
            ind_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            data_reg      <= data_next;
            to_port2_reg  <= to_port2_next;
            ind_port1_reg <= ind_port1_next;
            ind_port2_reg <= ind_port2_next;
            ind_error_reg <= ind_error_next;
        end
    end

    // Output ports driven straight from registered state
    always_comb begin
        busy        = (state_reg != IDLE);
        port1_valid = (state_reg == SEND) && !to_port2_reg;
        port2_valid = (state_reg == SEND) &&  to_port2_reg;
        port1_data  = data_reg;
        port2_data  = data_reg;
        ind_port1   = ind_port1_reg;
        ind_port2   = ind_port2_reg;
        ind_error   = ind_error_reg;
    end

`ifdef ROUTE_STATS_EN
    logic [STAT_W-1:0] fwd_count_reg, drop_count_reg;
    logic              fwd_evt, drop_evt;

    // Completion and drop events, one cycle wide, on the deciding edge
    always_comb begin
        fwd_evt  = (state_reg == SEND) && sel_ready;
        drop_evt = (accept && (acc_addr != ADDR_PORT1) && (acc_addr != ADDR_PORT2))
                || ((state_reg == SEND) && !sel_ready && (cnt_reg == '0));
    end

    // Saturating statistics counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwd_count_reg  <= '0;
            drop_count_reg <= '0;
        end else begin
            if (fwd_evt && (fwd_count_reg != '1)) begin
                fwd_count_reg <= fwd_count_reg + STAT_W'(1);
            end
            if (drop_evt && (drop_count_reg != '1)) begin
                drop_count_reg <= drop_count_reg + STAT_W'(1);
            end
        end
    end

    assign fwd_count  = fwd_count_reg;
    assign drop_count = drop_count_reg;
`endif

endmodule

// File: tb/tb_route_scheduler.sv
// Directed bench for route_scheduler with HOLD_CYCLES=4, TIMEOUT=8.
// Counter checks are compiled in when ROUTE_STATS_EN is defined.
module tb_route_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_a_valid = 1'b0, req_b_valid = 1'b0;
    logic [7:0] req_a_data = '0, req_b_data = '0;
    logic       req_a_ready, req_b_ready;
    logic       port1_valid, port2_valid;
    logic [7:0] port1_data, port2_data;
    logic       port1_ready = 1'b0, port2_ready = 1'b0;
    logic       ind_port1, ind_port2, ind_error, busy;
`ifdef ROUTE_STATS_EN
    logic [15:0] fwd_count, drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    route_scheduler #(.DATA_W(8), .HOLD_CYCLES(4), .TIMEOUT(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_a_valid (req_a_valid),
        .req_a_data  (req_a_data),
        .req_a_ready (req_a_ready),
        .req_b_valid (req_b_valid),
        .req_b_data  (req_b_data),
        .req_b_ready (req_b_ready),
        .port1_valid (port1_valid),
        .port1_data  (port1_data),
        .port1_ready (port1_ready),
        .port2_valid (port2_valid),
        .port2_data  (port2_data),
        .port2_ready (port2_ready),
        .ind_port1   (ind_port1),
        .ind_port2   (ind_port2),
        .ind_error   (ind_error),
        .busy        (busy)
`ifdef ROUTE_STATS_EN
        ,
        .fwd_count   (fwd_count),
        .drop_count  (drop_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
        port1_ready = 1'b0;
        port2_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Offer one packet on a channel, then observe ncyc cycles. Both port
    // readies are raised at cycle rdy_at (0 leaves them untouched).
    task automatic run_pkt(input bit use_b, input logic [7:0] d, input int ncyc,
                           input int rdy_at, output int v1, output int v2,
                           output int i1, output int i2, output int ie,
                           output logic [7:0] d1, output logic [7:0] d2);
        v1 = 0; v2 = 0; i1 = 0; i2 = 0; ie = 0; d1 = '0; d2 = '0;
        @(negedge clock);
        if (use_b) begin
            req_b_valid = 1'b1; req_b_data = d;
        end else begin
            req_a_valid = 1'b1; req_a_data = d;
        end
        #1;
        check(use_b ? "ready_b" : "ready_a", use_b ? req_b_ready : req_a_ready, 1);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clock);
            if (i == 1) begin
                req_a_valid = 1'b0;
                req_b_valid = 1'b0;
            end
            if (i == rdy_at) begin
                port1_ready = 1'b1;
                port2_ready = 1'b1;
            end
            #1;
            if (port1_valid) begin v1++; d1 = port1_data; end
            if (port2_valid) begin v2++; d2 = port2_data; end
            if (ind_port1) i1++;
            if (ind_port2) i2++;
            if (ind_error) ie++;
        end
        $display("pkt %s data=%h: v1=%0d v2=%0d i1=%0d i2=%0d ie=%0d",
                 use_b ? "B" : "A", d, v1, v2, i1, i2, ie);
    endtask

    initial begin
        int v1, v2, i1, i2, ie;
        logic [7:0] d1, d2;
        logic [1:0] g [4];
        logic [8:0] x [4];
        int ng, nx;

        // Reset state
        #2;
        check("rst_p1v", port1_valid, 0);
        check("rst_p2v", port2_valid, 0);
        check("rst_ind", {ind_port1, ind_port2, ind_error}, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy", {req_a_ready, req_b_ready}, 0);
`ifdef ROUTE_STATS_EN
        check("rst_cnt", {fwd_count, drop_count}, 0);
`endif
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Port 1 forward with immediate ready
        port1_ready = 1'b1;
        run_pkt(0, 8'h41, 12, 0, v1, v2, i1, i2, ie, d1, d2);
        check("t1_v1", v1, 1);
        check("t1_d1", d1, 8'h41);
        check("t1_v2", v2, 0);
        check("t1_i1", i1, 5);
        check("t1_ie", ie, 0);
`ifdef ROUTE_STATS_EN
        check("t1_fwd", fwd_count, 1);
        check("t1_drop", drop_count, 0);
`endif

        // Round-robin contention
        do_reset();
        port1_ready = 1'b1;
        port2_ready = 1'b1;
        ng = 0; nx = 0;
        @(negedge clock);
        req_a_valid = 1'b1; req_a_data = 8'h81;
        req_b_valid = 1'b1; req_b_data = 8'h42;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            if (req_a_ready || req_b_ready) begin
                if (ng < 4) g[ng] = req_b_ready ? 2'd2 : 2'd1;
                ng++;
            end
            if (port1_valid && port1_ready) begin
                if (nx < 4) x[nx] = {1'b0, port1_data};
                nx++;
            end
            if (port2_valid && port2_ready) begin
                if (nx < 4) x[nx] = {1'b1, port2_data};
                nx++;
            end
            if (i == 20) begin
                req_a_valid = 1'b0;
                req_b_valid = 1'b0;
            end
        end
        check("t2_ngrant", ng, 4);
        check("t2_nxfer", nx, 4);
        check("t2_grant", {g[0], g[1], g[2], g[3]}, {2'd1, 2'd2, 2'd1, 2'd2});
        check("t2_x0", x[0], {1'b1, 8'h81});
        check("t2_x1", x[1], {1'b0, 8'h42});
        check("t2_x2", x[2], {1'b1, 8'h81});
        check("t2_x3", x[3], {1'b0, 8'h42});
        $display("contention: grants=%0d transfers=%0d", ng, nx);

        // Address error
        do_reset();
        port1_ready = 1'b1;
        port2_ready = 1'b1;
        run_pkt(1, 8'hC5, 10, 0, v1, v2, i1, i2, ie, d1, d2);
        check("t3_valid", {v1[7:0], v2[7:0]}, 0);
        check("t3_ie", ie, 4);
        check("t3_ip", {i1[7:0], i2[7:0]}, 0);
`ifdef ROUTE_STATS_EN
        check("t3_drop", drop_count, 1);
        check("t3_fwd", fwd_count, 0);
`endif

        // Timeout on port 2
        do_reset();
        run_pkt(0, 8'h80, 16, 0, v1, v2, i1, i2, ie, d1, d2);
        check("t4_v2", v2, 8);
        check("t4_d2", d2, 8'h80);
        check("t4_i2", i2, 8);
        check("t4_ie", ie, 4);
        check("t4_v1", v1, 0);
`ifdef ROUTE_STATS_EN
        check("t4_drop", drop_count, 1);
        check("t4_fwd", fwd_count, 0);
`endif

        // Ready in the last timeout cycle still completes the transfer
        do_reset();
        run_pkt(0, 8'h80, 16, 8, v1, v2, i1, i2, ie, d1, d2);
        check("t4b_v2", v2, 8);
        check("t4b_i2", i2, 12);
        check("t4b_ie", ie, 0);
`ifdef ROUTE_STATS_EN
        check("t4b_fwd", fwd_count, 1);
        check("t4b_drop", drop_count, 0);
`endif

        // Asynchronous reset during SEND
        do_reset();
        @(negedge clock);
        req_a_valid = 1'b1; req_a_data = 8'h41;
        @(negedge clock);
        req_a_valid = 1'b0;
        #1;
        check("t5_send", port1_valid, 1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        req_a_valid = 1'b1; req_a_data = 8'h41;
        req_b_valid = 1'b1; req_b_data = 8'h42;
        #1;
        check("t5_p1v", port1_valid, 0);
        check("t5_ind", {ind_port1, ind_port2, ind_error}, 0);
        check("t5_busy", busy, 0);
        check("t5_rdy_in_rst", {req_a_ready, req_b_ready}, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t5_grant", {req_a_ready, req_b_ready}, 2'b10);
`ifdef ROUTE_STATS_EN
        check("t5_cnt", {fwd_count, drop_count}, 0);
`endif
        port1_ready = 1'b1;
        @(negedge clock);
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
        #1;
        check("t5_after", {port1_valid, port1_data}, {1'b1, 8'h41});
        $display("reset mid-send: reaccept data=%h", port1_data);

`ifdef ROUTE_STATS_EN
        // Saturation of the forward counter
        do_reset();
        force dut.fwd_count_reg = 16'hFFFF;
        @(negedge clock);
        release dut.fwd_count_reg;
        check("t6_pre", fwd_count, 16'hFFFF);
        port1_ready = 1'b1;
        run_pkt(0, 8'h41, 8, 0, v1, v2, i1, i2, ie, d1, d2);
        check("t6_v1", v1, 1);
        check("t6_sat", fwd_count, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/route_scheduler.md
# route_scheduler

Schedules packets from two SPI receive channels onto the router's two output ports. Arbitrates round-robin between the channels, decodes each packet's 2-bit address field, and forwards it to port 1 or port 2 with a valid/ready handshake. Packets with an invalid address, or that the port does not accept in time, are dropped as errors. It drives the one-hot `ind_port1` / `ind_port2` / `ind_error` indications that feed the board LED generator, holding each for a fixed display time.

## Interface
Parameters:
- `DATA_W`, 8: packet width; address field is `data[DATA_W-1:DATA_W-2]`.
- `HOLD_CYCLES`, 1000: cycles an indication is held after a packet completes; must be ≥1.
- `TIMEOUT`, 255: maximum cycles spent in SEND waiting for port ready; must be ≥1.

Ports:
- `clock` in 1: single clock, all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_a_valid` in 1 / `req_a_data` in DATA_W / `req_a_ready` out 1: channel A handshake.
- `req_b_valid` in 1 / `req_b_data` in DATA_W / `req_b_ready` out 1: channel B handshake.
- `port1_valid` out 1 / `port1_data` out DATA_W / `port1_ready` in 1: output port 1.
- `port2_valid` out 1 / `port2_data` out DATA_W / `port2_ready` in 1: output port 2.
- `ind_port1`, `ind_port2`, `ind_error` out 1 each: one-hot indication to the LED generator.
- `busy` out 1: high whenever the state is not IDLE.
- `fwd_count` out 16, `drop_count` out 16: present only with `ROUTE_STATS_EN`.

## Operation
- States: IDLE, SEND, HOLD.
- **IDLE**
  - `req_x_ready` = (state==IDLE) && grant_x. This is combinational from the valids and the priority pointer.
  - Grant rule:
    - If only one channel is valid, it is granted.
    - If both are valid, the channel not served last is granted.
    - After reset, A has priority.
  - Acceptance happens on valid&&ready.
  - On acceptance: register the data, toggle the priority pointer to the other channel, and decode the address field:
    - `2'b01`: go to SEND toward port 1, set `ind_port1`.
    - `2'b10`: go to SEND toward port 2, set `ind_port2`.
    - `2'b00` or `2'b11`: go to HOLD, set `ind_error`, increment drop.
- **SEND**
  - Selected `portN_valid`=1 with `portN_data` = the registered packet, held stable.
  - The other port's valid stays 0.
  - On `portN_ready`: transfer completes, go to HOLD, increment fwd.
  - If ready has not been seen after TIMEOUT cycles in SEND: deassert valid, clear `ind_portN`, set `ind_error`, go to HOLD, increment drop.
- **HOLD**
  - Indication unchanged, both port valids 0, both readies 0.
  - After HOLD_CYCLES cycles: clear all indications and go to IDLE.
- Indications are registered and always one-hot or all-zero.
- While busy, both readies are 0; upstream channels must hold their valid and data until accepted.
- Reset (including mid-SEND or mid-HOLD):
  - All outputs 0, state IDLE, counters 0, priority to A.
  - Any in-flight packet is discarded and not counted.

## Timing
- Acceptance at edge k: SEND and `ind_portN`=1 visible after edge k.
- If `portN_ready`=1 in the first SEND cycle, transfer at edge k+1. HOLD then spans cycles k+1..k+HOLD_CYCLES, and IDLE is reached at edge k+1+HOLD_CYCLES.
- Minimum accept-to-accept spacing is HOLD_CYCLES+2 cycles.
- Error packet: `ind_error`=1 after edge k, IDLE at edge k+HOLD_CYCLES.
- Timeout: if ready never arrives, valid is high for exactly TIMEOUT cycles, then `ind_error`=1 for HOLD_CYCLES cycles.
- Ready arriving in the same cycle the timeout expires counts as a successful transfer.
- Counters update on the edge of completion or drop.
- Counters saturate at 16'hFFFF and never wrap.

## Configuration
- `ROUTE_STATS_EN` defined:
  - `fwd_count` and `drop_count` ports and registers exist.
  - `fwd_count` counts completed transfers.
  - `drop_count` counts address errors plus timeouts.
- Undefined: both ports and both counters are absent. All other behaviour is identical.

## Structure
- Shared package `router_pkg` holds:
  - state enum `sched_state_t` {IDLE, SEND, HOLD}
  - constants `ADDR_PORT1`=2'b01 and `ADDR_PORT2`=2'b10
  - localparam `STAT_W`=16
- Sub-module `rr_arbiter2`: two request inputs, one-hot grant outputs, and the priority pointer. The pointer updates on an accept strobe and resets to A.
- Hold and timeout share one down-counter sized `$clog2(max(HOLD_CYCLES,TIMEOUT)+1)`.

## Test plan
1. **Port 1 forward.** HOLD_CYCLES=4, A sends 8'h41, `port1_ready`=1.
   - `port1_valid` for 1 cycle with data 41.
   - `ind_port1` high 5 cycles.
   - `fwd_count`=1.
2. **Round-robin contention.** A and B valid continuously; A=8'h81, B=8'h42.
   - Grant order A, B, A, B.
   - Port 2 receives 81 and port 1 receives 42, alternately.
3. **Address error.** B sends 8'hC5.
   - No port valid.
   - `ind_error` high HOLD_CYCLES cycles.
   - `drop_count`=1.
4. **Timeout.** TIMEOUT=8, `port2_ready`=0, A sends 8'h80.
   - `port2_valid` high exactly 8 cycles.
   - `ind_port2` then replaced by `ind_error`; `drop_count`=1.
5. **Reset mid-SEND.** `port1_ready`=0, assert reset during SEND.
   - All outputs 0 immediately (asynchronous).
   - Next simultaneous request is granted to A.
   - Counters 0.
6. **Saturation and compile-out.**
   - With `ROUTE_STATS_EN`: force `fwd_count` to FFFF, forward one packet; the count stays FFFF.
   - Without the macro: the build compiles with the stats ports absent.
